// File: rtl/ldpc_ber_tester_status_monitor_if.sv
// Decoder STATUS stream and histogram read bus shared by the status monitor and its driver.
interface ldpc_ber_tester_status_monitor_if #(
    parameter int ITER_W = 6,
    parameter int BIN_W  = 32
);
    logic [31:0]       s_axis_status_tdata;
    logic              s_axis_status_tvalid;
    logic              s_axis_status_tready;
    logic              hist_rd;
    logic [ITER_W-1:0] hist_addr;
    logic [BIN_W-1:0]  hist_data;
    logic              hist_valid;

    modport master (
        output s_axis_status_tdata, s_axis_status_tvalid, hist_rd, hist_addr,
        input  s_axis_status_tready, hist_data, hist_valid
    );

    modport slave (
        input  s_axis_status_tdata, s_axis_status_tvalid, hist_rd, hist_addr,
        output s_axis_status_tready, hist_data, hist_valid
    );
endinterface

// File: rtl/ldpc_ber_tester_status_monitor.sv
// Decoder status sink: block counters, ID sequence check and per-iteration histogram.
// Histogram RAM, clearing sweep and RMW forwarding are built only with LDPC_STATUS_MON_HIST_EN.
module ldpc_ber_tester_status_monitor #(
    parameter int ITER_W = 6,
    parameter int ID_W   = 8,
    parameter int CNT_W  = 48,
    parameter int BIN_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    ldpc_ber_tester_status_monitor_if.slave bus,
    output logic [CNT_W-1:0]    total_blocks,
    output logic [CNT_W-1:0]    failed_blocks,
    output logic [CNT_W-1:0]    iter_sum,
    output logic [ITER_W-1:0]   max_iter,
    output logic [31:0]         seq_errors,
    output logic                busy
);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [BIN_W-1:0] sat_inc_bin(input logic [BIN_W-1:0] v);
        return (&v) ? v : v + BIN_W'(1);
    endfunction

    logic [ID_W-1:0]   w_id, w_exp_id, r_prev_id;
    logic [ITER_W-1:0] w_iter, r_max;
    logic              w_pass, w_acc, w_tready, w_busy, r_id_vld;
    logic [CNT_W-1:0]  r_total, r_failed, r_sum;
    logic [31:0]       r_seq;
    logic              w_unused_tdata;

    assign w_id     = bus.s_axis_status_tdata[ID_W-1:0];
    assign w_iter   = bus.s_axis_status_tdata[8+ITER_W-1:8];
    assign w_pass   = bus.s_axis_status_tdata[16];
    assign w_exp_id = r_prev_id + ID_W'(1);
    assign w_unused_tdata = ^bus.s_axis_status_tdata;

    // A beat arriving in the same cycle as clear is discarded with the old statistics.
    assign bus.s_axis_status_tready = w_tready & !reset;
    assign w_acc  = bus.s_axis_status_tvalid & bus.s_axis_status_tready & !clear;
    assign busy   = w_busy;

    // Stage p0 -> counters: statistics visible the cycle after accept
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_total  <= '0;
            r_failed <= '0;
            r_sum    <= '0;
            r_max    <= '0;
            r_seq    <= '0;
            r_id_vld <= 1'b0;
        end else if (w_acc) begin
            r_total  <= r_total + CNT_W'(1);
            if (!w_pass)
                r_failed <= r_failed + CNT_W'(1);
            r_sum    <= r_sum + CNT_W'(w_iter);
            if (w_iter > r_max)
                r_max <= w_iter;
            if (r_id_vld && (w_id != w_exp_id))
                r_seq <= sat_inc32(r_seq);
            r_id_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc)
            r_prev_id <= w_id;
    end

    assign total_blocks  = r_total;
    assign failed_blocks = r_failed;
    assign iter_sum      = r_sum;
    assign max_iter      = r_max;
    assign seq_errors    = r_seq;

`ifdef LDPC_STATUS_MON_HIST_EN
    typedef enum logic {ST_SWEEP, ST_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [ITER_W-1:0] r_swp_addr, w_swp_addr_nxt;
    logic              w_swp_we;
    logic [BIN_W-1:0]  r_hist [0:(1<<ITER_W)-1];
    logic              r_vld_p1, r_vld_p2, w_upd_we;
    logic [ITER_W-1:0] r_iter_p1, r_iter_p2;
    logic [BIN_W-1:0]  r_rdat_p1, r_wdat_p2, w_base, w_inc;
    logic [BIN_W-1:0]  r_hist_data;
    logic              r_hist_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SWEEP;
            r_swp_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_swp_addr <= w_swp_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_swp_addr_nxt = r_swp_addr;
        w_swp_we       = 1'b0;
        w_tready       = 1'b0;
        w_busy         = 1'b0;
        case (r_state)
            ST_SWEEP: begin
                w_busy         = 1'b1;
                w_swp_we       = 1'b1;
                w_swp_addr_nxt = r_swp_addr + ITER_W'(1);
                if (&r_swp_addr)
                    w_state_nxt = ST_RUN;
            end
            default: w_tready = 1'b1;
        endcase
        if (clear) begin
            w_state_nxt    = ST_SWEEP;
            w_swp_addr_nxt = '0;
        end
    end

    // Stage p1: read the bin; p2 value forwarded when the previous write hit the same bin
    assign w_base   = (r_vld_p2 && (r_iter_p2 == r_iter_p1)) ? r_wdat_p2 : r_rdat_p1;
    assign w_inc    = sat_inc_bin(w_base);
    assign w_upd_we = r_vld_p1 & !clear & !reset;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= w_acc;
            r_vld_p2 <= w_upd_we;
        end
    end

    always_ff @(posedge clk) begin
        r_iter_p1 <= w_iter;
        r_rdat_p1 <= r_hist[w_iter];
        r_iter_p2 <= r_iter_p1;
        r_wdat_p2 <= w_inc;
    end

    // Stage p2: single write port shared by the sweep and the increment
    always_ff @(posedge clk) begin
        if (w_swp_we)
            r_hist[r_swp_addr] <= '0;
        else if (w_upd_we)
            r_hist[r_iter_p1] <= w_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist_data <= '0;
            r_hist_vld  <= 1'b0;
        end else begin
            r_hist_vld <= bus.hist_rd;
            if (bus.hist_rd)
                r_hist_data <= r_hist[bus.hist_addr];
        end
    end

    assign bus.hist_data  = r_hist_data;
    assign bus.hist_valid = r_hist_vld;
`else
    logic r_run;
    logic r_hist_vld;
    logic w_unused_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run      <= 1'b0;
            r_hist_vld <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_hist_vld <= bus.hist_rd;
        end
    end

    assign w_tready       = r_run;
    assign w_busy         = 1'b0;
    assign w_unused_addr  = ^bus.hist_addr;
    assign bus.hist_data  = '0;
    assign bus.hist_valid = r_hist_vld;
`endif

endmodule

// File: tb/tb_ldpc_ber_tester_status_monitor.sv
// Directed scoreboard bench for the status monitor; expectations follow LDPC_STATUS_MON_HIST_EN.
module tb_ldpc_ber_tester_status_monitor;
    localparam int ITER_W = 6;
    localparam int ID_W   = 8;
    localparam int CNT_W  = 48;
    localparam int BIN_W  = 32;
`ifdef LDPC_STATUS_MON_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    localparam int S_TOTAL = 0, S_FAILED = 1, S_SUM = 2, S_MAX = 3, S_SEQ = 4, S_BUSY = 5, S_TREADY = 6;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset, clear;
    logic [CNT_W-1:0]  total_blocks, failed_blocks, iter_sum;
    logic [ITER_W-1:0] max_iter;
    logic [31:0]       seq_errors;
    logic              busy;

    exp_t        snap_q[$];
    logic [63:0] hist_q[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    ldpc_ber_tester_status_monitor_if #(.ITER_W(ITER_W), .BIN_W(BIN_W)) bus ();

    ldpc_ber_tester_status_monitor #(
        .ITER_W(ITER_W), .ID_W(ID_W), .CNT_W(CNT_W), .BIN_W(BIN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .bus(bus),
        .total_blocks(total_blocks),
        .failed_blocks(failed_blocks),
        .iter_sum(iter_sum),
        .max_iter(max_iter),
        .seq_errors(seq_errors),
        .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] probe(input int sel);
        case (sel)
            S_TOTAL:  return 64'(total_blocks);
            S_FAILED: return 64'(failed_blocks);
            S_SUM:    return 64'(iter_sum);
            S_MAX:    return 64'(max_iter);
            S_SEQ:    return 64'(seq_errors);
            S_BUSY:   return 64'(busy);
            default:  return 64'(bus.s_axis_status_tready);
        endcase
    endfunction

    // Monitor: drains pending status snapshots and pairs every hist_valid with its queued read
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] h;
        while (snap_q.size() > 0) begin
            e = snap_q.pop_front();
            check(e.name, probe(e.sel), e.exp);
        end
        if (bus.hist_valid === 1'b1) begin
            if (hist_q.size() == 0) begin
                check("hist_unexpected_valid", 64'(bus.hist_valid), 64'd0);
            end else begin
                h = hist_q.pop_front();
                check("hist_data", 64'(bus.hist_data), h);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int sel, input logic [63:0] v, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        snap_q.push_back(e);
    endtask

    task automatic expect_stats(input logic [63:0] tot, input logic [63:0] fl, input logic [63:0] sm,
                                input logic [63:0] mx, input logic [63:0] sq, input string tag);
        expect_val(S_TOTAL,  tot, {tag, "_total"});
        expect_val(S_FAILED, fl,  {tag, "_failed"});
        expect_val(S_SUM,    sm,  {tag, "_iter_sum"});
        expect_val(S_MAX,    mx,  {tag, "_max_iter"});
        expect_val(S_SEQ,    sq,  {tag, "_seq_errors"});
    endtask

    task automatic present(input int id, input int iter, input bit pass);
        bus.s_axis_status_tdata  = {15'd0, pass, 2'b00, iter[5:0], id[7:0]};
        bus.s_axis_status_tvalid = 1'b1;
    endtask

    // Presents one beat and returns just after its accepting edge, leaving tvalid high
    task automatic send(input int id, input int iter, input bit pass);
        int n;
        present(id, iter, pass);
        n = 0;
        while (bus.s_axis_status_tready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (bus.s_axis_status_tready !== 1'b1)
            check("send_tready_timeout", 64'(bus.s_axis_status_tready), 64'd1);
        tick();
    endtask

    task automatic idle();
        bus.s_axis_status_tvalid = 1'b0;
    endtask

    task automatic read_bin(input int b, input logic [63:0] exp);
        bus.hist_rd   = 1'b1;
        bus.hist_addr = b[ITER_W-1:0];
        hist_q.push_back(exp);
        tick();
        check("hist_valid_latency", 64'(bus.hist_valid), 64'd1);
        bus.hist_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        if (busy !== 1'b0)
            check("busy_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stall;
        reset = 1'b1;
        clear = 1'b0;
        bus.s_axis_status_tdata  = '0;
        bus.s_axis_status_tvalid = 1'b0;
        bus.hist_rd   = 1'b0;
        bus.hist_addr = '0;
        tick(3);

        // Reset state
        expect_val(S_BUSY,   64'(HIST), "reset_busy");
        expect_val(S_TREADY, 64'd0,     "reset_tready");
        expect_stats(0, 0, 0, 0, 0, "reset");
        reset = 1'b0;

        // Post-reset sweep length
        n = 0;
        stall = 0;
        while (bus.s_axis_status_tready !== 1'b1 && n < 300) begin
            if (busy !== HIST) stall++;
            tick();
            n++;
        end
        check("sweep_cycles", 64'(n), HIST ? 64'd64 : 64'd1);
        check("sweep_busy_held", 64'(stall), 64'd0);
        expect_val(S_BUSY, 64'd0, "run_busy");
        for (int b = 0; b < (1 << ITER_W); b++)
            read_bin(b, 64'd0);
        tick(3);

        // Ten in-order passing blocks, iter 5
        for (int i = 0; i < 10; i++)
            send(i, 5, 1'b1);
        idle();
        tick(3);
        expect_stats(10, 0, 50, 5, 0, "stream10");
        read_bin(5, HIST ? 64'd10 : 64'd0);
        read_bin(4, 64'd0);
        tick(3);

        // Back-to-back hits on one bin, then an interleaved pattern
        do_clear();
        expect_stats(0, 0, 0, 0, 0, "clear1");
        for (int i = 0; i < 4; i++)
            send(i, 3, 1'b1);
        idle();
        tick(3);
        read_bin(3, HIST ? 64'd4 : 64'd0);
        send(4, 3, 1'b1);
        send(5, 7, 1'b1);
        send(6, 3, 1'b1);
        idle();
        tick(3);
        read_bin(3, HIST ? 64'd6 : 64'd0);
        read_bin(7, HIST ? 64'd1 : 64'd0);
        expect_stats(7, 0, 25, 7, 0, "fwd");
        tick(2);

        // ID gap, parity failure and ID wrap
        do_clear();
        send(0, 2, 1'b1);
        send(1, 2, 1'b1);
        send(2, 2, 1'b1);
        send(5, 2, 1'b1);
        send(6, 2, 1'b1);
        idle();
        tick(2);
        expect_stats(5, 0, 10, 2, 1, "gap");
        send(6, 2, 1'b0);
        idle();
        tick();
        expect_stats(6, 1, 12, 2, 2, "repeat_fail");
        send(255, 2, 1'b1);
        idle();
        tick();
        expect_val(S_SEQ, 64'd3, "jump_to_255_seq");
        send(0, 2, 1'b1);
        idle();
        tick();
        expect_stats(8, 1, 16, 2, 3, "wrap");

        // Clear while the stream is running and a beat is being offered
        do_clear();
        for (int i = 0; i < 20; i++)
            send(i, 1, 1'b1);
        expect_val(S_TOTAL, 64'd20, "midstream_total");
        present(20, 1, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_stats(0, 0, 0, 0, 0, "after_clear");
        n = 0;
        stall = 0;
        while (busy === 1'b1 && n < 300) begin
            if (bus.s_axis_status_tready !== 1'b0) stall++;
            tick();
            n++;
        end
        check("clear_busy_cycles", 64'(n), HIST ? 64'd64 : 64'd0);
        check("clear_no_tready", 64'(stall), 64'd0);
        expect_val(S_TOTAL, 64'd0, "sweep_end_total");
        tick();
        idle();
        tick(3);
        expect_stats(1, 0, 1, 1, 0, "post_clear_beat");
        read_bin(1, HIST ? 64'd1 : 64'd0);
        tick(3);

`ifdef LDPC_STATUS_MON_HIST_EN
        // Saturation of a bin preloaded one below full scale
        do_clear();
        dut.r_hist[9] = 32'hFFFF_FFFE;
        send(0, 9, 1'b1);
        send(1, 9, 1'b1);
        idle();
        tick(3);
        read_bin(9, 64'hFFFF_FFFF);
        tick(2);
        send(2, 9, 1'b1);
        idle();
        tick(3);
        read_bin(9, 64'hFFFF_FFFF);
        tick(3);
`endif

        tick(3);
        check("hist_reads_outstanding", 64'(hist_q.size()), 64'd0);
        check("snapshots_outstanding", 64'(snap_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
